// File: rtl/gptp_rx_pkg.sv
// gPTP receive dispatch: shared message types, default filter mask and
// frame field offset helpers used by the dispatcher and its arbiter.
package gptp_rx_pkg;

  typedef enum logic [3:0] {
    SYNC           = 4'h0,
    DELAY_REQ      = 4'h1,
    PDELAY_REQ     = 4'h2,
    PDELAY_RESP    = 4'h3,
    FOLLOW_UP      = 4'h8,
    PDELAY_RESP_FU = 4'hA,
    ANNOUNCE       = 4'hB,
    SIGNALING      = 4'hC
  } msg_type_e;

  // Event messages plus FOLLOW_UP and PDELAY_RESP_FU are forwarded.
  localparam logic [15:0] DEF_TYPE_MASK = 16'h050F;

  localparam int PORT_IDX_W = 4;
  localparam int ADDR_W     = 8;
  localparam int CNT_W      = 16;

  // Receive timestamp sits at the bottom of the frame.
  function automatic int ts1_lo();
    return 0;
  endfunction

  // messageType nibble sits just above the receive timestamp.
  function automatic int type_lo(input int ts_w);
    return ts_w;
  endfunction

  // Carried timestamp occupies the top TS_W bits of the frame.
  function automatic int ts2_lo(input int frame_w, input int ts_w);
    return frame_w - ts_w;
  endfunction

endpackage

// File: rtl/gptp_rr_arb.sv
// Round-robin arbiter: one-hot grant and index over a request vector.
// Ports: i_clk, i_rst, i_req, i_adv (grant consumed), o_gnt, o_idx.
module gptp_rr_arb
  import gptp_rx_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N-1:0]          i_req,
  input  logic                  i_adv,
  output logic [N-1:0]          o_gnt,
  output logic [PORT_IDX_W-1:0] o_idx
);

  // Last granted port; reset to N-1 so port 0 has top priority.
  logic [PORT_IDX_W-1:0] r_last;
  logic [N-1:0]          w_mask;
  logic [N-1:0]          w_hi;
  logic [N-1:0]          w_sel;

  // Ports strictly above the last grant get first pick.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (5'(i) > {1'b0, r_last});
    end
  end

  assign w_hi  = i_req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : i_req;

  // Lowest set bit of the selected vector wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = PORT_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= PORT_IDX_W'(N - 1);
    end else if (i_adv) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/gptp_rx_dispatch.sv
// gPTP receive dispatcher: arbitrates per-port frames, filters by type,
// and presents one record (tag + two timestamps) to a downstream store.
// Ports: clk, reset, gptp_rv_{data,vaild,ready}, rx_rev_wr_{ready,vaild,
// addr,data1,data2}, drop_cnt (per-port filtered-frame counters).
module gptp_rx_dispatch
  import gptp_rx_pkg::*;
#(
  parameter int          NUM_PORTS = 4,
  parameter int          TS_W      = 80,
  parameter int          FRAME_W   = 432,
  parameter logic [15:0] TYPE_MASK = DEF_TYPE_MASK
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*FRAME_W-1:0] gptp_rv_data,
  input  logic [NUM_PORTS-1:0]         gptp_rv_vaild,
  output logic [NUM_PORTS-1:0]         gptp_rv_ready,
  input  logic                         rx_rev_wr_ready,
  output logic                         rx_rev_wr_vaild,
  output logic [ADDR_W-1:0]            rx_rev_wr_addr,
  output logic [TS_W-1:0]              rx_rev_wr_data1,
  output logic [TS_W-1:0]              rx_rev_wr_data2,
  output logic [NUM_PORTS*CNT_W-1:0]   drop_cnt
);

  localparam int TS1_LO  = ts1_lo();
  localparam int TYPE_LO = type_lo(TS_W);
  localparam int TS2_LO  = ts2_lo(FRAME_W, TS_W);

  logic [NUM_PORTS-1:0]  w_gnt;
  logic [PORT_IDX_W-1:0] w_gidx;
  logic                  w_load_en;
  logic                  w_take;
  logic                  w_fwd;
  logic [FRAME_W-1:0]    w_frame;
  logic [3:0]            w_type;
  logic                  w_unused;

  logic                  r_vld;
  logic [ADDR_W-1:0]     r_addr;
  logic [TS_W-1:0]       r_d1;
  logic [TS_W-1:0]       r_d2;
  logic [CNT_W-1:0]      r_drop [NUM_PORTS];

  gptp_rr_arb #(
    .N (NUM_PORTS)
  ) u_arb (
    .i_clk (clk),
    .i_rst (reset),
    .i_req (gptp_rv_vaild),
    .i_adv (w_take),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  // Record slot free, or being drained this cycle.
  assign w_load_en = !r_vld || rx_rev_wr_ready;

  // Reset gating keeps upstream from seeing an accept while in reset.
  assign gptp_rv_ready =
    w_gnt & {NUM_PORTS{w_load_en && !reset}};

  assign w_take = |(gptp_rv_vaild & gptp_rv_ready);

  always_comb begin
    w_frame = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt[p]) begin
        w_frame = gptp_rv_data[p*FRAME_W +: FRAME_W];
      end
    end
  end

  assign w_type   = w_frame[TYPE_LO +: 4];
  assign w_fwd    = TYPE_MASK[w_type];
  // Frame bits between the fields are payload this block ignores.
  assign w_unused = ^w_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
    end else if (w_load_en) begin
      // Drain without a new forwardable frame empties the slot.
      r_vld <= w_take && w_fwd;
      if (w_take && w_fwd) begin
        r_addr <= {w_gidx, w_type};
        r_d1   <= w_frame[TS1_LO +: TS_W];
        r_d2   <= w_frame[TS2_LO +: TS_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_drop[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_take && !w_fwd && w_gnt[p] &&
            r_drop[p] != {CNT_W{1'b1}}) begin
          r_drop[p] <= r_drop[p] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    assign drop_cnt[p*CNT_W +: CNT_W] = r_drop[p];
  end

  assign rx_rev_wr_vaild = r_vld;
  assign rx_rev_wr_addr  = r_addr;
  assign rx_rev_wr_data1 = r_d1;
  assign rx_rev_wr_data2 = r_d2;

endmodule

// File: tb/tb_gptp_rx_dispatch.sv
// Directed bench for gptp_rx_dispatch: forwarding, round-robin order,
// backpressure, type filtering with saturation, and mid-run reset.
module tb_gptp_rx_dispatch;

  localparam int NP = 4;
  localparam int TW = 80;
  localparam int FW = 432;

  localparam logic [TW-1:0] T1 = 80'h123456789abc00000001;
  localparam logic [TW-1:0] T2 = 80'h123456789abc00000002;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*FW-1:0] data;
  logic [NP-1:0]    vaild;
  logic [NP-1:0]    ready;
  logic             wr_ready;
  logic             wr_vaild;
  logic [7:0]       addr;
  logic [TW-1:0]    d1;
  logic [TW-1:0]    d2;
  logic [NP*16-1:0] drop;

  int n_tests = 0;
  int n_fail  = 0;

  gptp_rx_dispatch dut (
    .clk             (clk),
    .reset           (reset),
    .gptp_rv_data    (data),
    .gptp_rv_vaild   (vaild),
    .gptp_rv_ready   (ready),
    .rx_rev_wr_ready (wr_ready),
    .rx_rev_wr_vaild (wr_vaild),
    .rx_rev_wr_addr  (addr),
    .rx_rev_wr_data1 (d1),
    .rx_rev_wr_data2 (d2),
    .drop_cnt        (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(
    input logic [TW-1:0] t1,
    input logic [TW-1:0] t2,
    input logic [3:0]    ty
  );
    logic [FW-1:0] f;
    f = '0;
    f[TW-1:0]     = t1;
    f[TW+3:TW]    = ty;
    f[FW-1 -: TW] = t2;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Port p gets t1 = 0x100+p, t2 = 0x200+p, type p (all forwarded).
  task automatic load_rr_frames();
    for (int p = 0; p < NP; p++) begin
      data[p*FW +: FW] = mk(80'(32'h100 + p), 80'(32'h200 + p), 4'(p));
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    data     = '0;
    vaild    = '0;
    wr_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (wr_vaild !== 1'b0 || addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl: vaild=%b addr=%h want 0/00",
               wr_vaild, addr);
    end
    n_tests++;
    if (d1 !== '0 || d2 !== '0) begin
      n_fail++;
      $display("FAIL reset_data: d1=%h d2=%h want 0", d1, d2);
    end
    n_tests++;
    if (drop !== '0) begin
      n_fail++;
      $display("FAIL reset_drop: got %h want 0", drop);
    end
  endtask

  task automatic test_single();
    data[0 +: FW] = mk(T1, T2, 4'h3);
    vaild = 4'b0001;
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", ready);
    end
    tick();
    vaild = '0;
    n_tests++;
    if (wr_vaild !== 1'b1 || addr !== 8'h03 ||
        d1 !== T1 || d2 !== T2) begin
      n_fail++;
      $display("FAIL single_rec: v=%b a=%h d1=%h d2=%h want 1/03/%h/%h",
               wr_vaild, addr, d1, d2, T1, T2);
    end
    tick();
    n_tests++;
    if (wr_vaild !== 1'b0) begin
      n_fail++;
      $display("FAIL single_clear: got %b want 0", wr_vaild);
    end
  endtask

  task automatic test_port2();
    data[2*FW +: FW] = mk(T1, T2, 4'h3);
    vaild = 4'b0100;
    tick();
    vaild = '0;
    n_tests++;
    if (wr_vaild !== 1'b1 || addr !== 8'h23 || d1 !== T1) begin
      n_fail++;
      $display("FAIL port2_rec: v=%b a=%h d1=%h want 1/23/%h",
               wr_vaild, addr, d1, T1);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0]    ea;
    logic [TW-1:0] e1;
    logic [TW-1:0] e2;
    do_reset();
    load_rr_frames();
    wr_ready = 1'b1;
    vaild    = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      ea = {4'(k % 4), 4'(k % 4)};
      e1 = 80'(32'h100 + (k % 4));
      e2 = 80'(32'h200 + (k % 4));
      n_tests++;
      if (wr_vaild !== 1'b1 || addr !== ea || d1 !== e1 || d2 !== e2) begin
        n_fail++;
        $display("FAIL rr_%0d: v=%b a=%h d1=%h d2=%h want 1/%h/%h/%h",
                 k, wr_vaild, addr, d1, d2, ea, e1, e2);
      end
    end
  endtask

  // Runs straight after the round-robin test: port 3's record is held.
  task automatic test_backpressure();
    wr_ready = 1'b0;
    #1;
    n_tests++;
    if (ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_ready0: got %b want 0000", ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (wr_vaild !== 1'b1 || addr !== 8'h33 ||
          d1 !== 80'h103 || d2 !== 80'h203 || ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: v=%b a=%h d1=%h d2=%h rdy=%b want 1/33/103/203/0000",
                 k, wr_vaild, addr, d1, d2, ready);
      end
    end
    wr_ready = 1'b1;
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0001", ready);
    end
    tick();
    vaild = '0;
    n_tests++;
    if (wr_vaild !== 1'b1 || addr !== 8'h00 || d1 !== 80'h100) begin
      n_fail++;
      $display("FAIL bp_b2b: v=%b a=%h d1=%h want 1/00/100",
               wr_vaild, addr, d1);
    end
    tick();
    n_tests++;
    if (wr_vaild !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain_clear: got %b want 0", wr_vaild);
    end
  endtask

  task automatic test_drop();
    do_reset();
    wr_ready = 1'b1;
    data[1*FW +: FW] = mk(T1, T2, 4'hF);
    vaild = 4'b0010;
    #1;
    n_tests++;
    if (ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_ready: got %b want 0010", ready);
    end
    tick();
    n_tests++;
    if (wr_vaild !== 1'b0 || drop[16 +: 16] !== 16'd1) begin
      n_fail++;
      $display("FAIL drop_first: v=%b cnt=%h want 0/0001",
               wr_vaild, drop[16 +: 16]);
    end
    repeat (65533) tick();
    n_tests++;
    if (drop[16 +: 16] !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL drop_fffe: got %h want fffe", drop[16 +: 16]);
    end
    tick();
    n_tests++;
    if (drop[16 +: 16] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL drop_ffff: got %h want ffff", drop[16 +: 16]);
    end
    repeat (5) tick();
    n_tests++;
    if (drop[16 +: 16] !== 16'hFFFF || wr_vaild !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_sat: cnt=%h v=%b want ffff/0",
               drop[16 +: 16], wr_vaild);
    end
    n_tests++;
    if (drop[0 +: 16] !== 16'h0 || drop[32 +: 32] !== 32'h0) begin
      n_fail++;
      $display("FAIL drop_others: got %h want 0", drop);
    end
    vaild = '0;
    tick();
  endtask

  // Pointer left at port 1 so a missing pointer reset shows up.
  task automatic test_reset_mid();
    data[1*FW +: FW] = mk(T1, T2, 4'h8);
    vaild    = 4'b0010;
    wr_ready = 1'b0;
    tick();
    n_tests++;
    if (wr_vaild !== 1'b1 || addr !== 8'h18) begin
      n_fail++;
      $display("FAIL mid_load: v=%b a=%h want 1/18", wr_vaild, addr);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (wr_vaild !== 1'b0 || ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_async: v=%b rdy=%b want 0/0000",
               wr_vaild, ready);
    end
    tick();
    n_tests++;
    if (drop !== '0 || addr !== 8'h00 || d1 !== '0) begin
      n_fail++;
      $display("FAIL mid_clear: drop=%h a=%h d1=%h want 0",
               drop, addr, d1);
    end
    load_rr_frames();
    vaild    = 4'b1111;
    wr_ready = 1'b1;
    reset    = 1'b0;
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_gnt: got %b want 0001", ready);
    end
    tick();
    vaild = '0;
    n_tests++;
    if (wr_vaild !== 1'b1 || addr !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_first_rec: v=%b a=%h want 1/00",
               wr_vaild, addr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_port2();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gptp_rx_dispatch.md
GPTP_RX_DISPATCH -- requirements
Module: gptp_rx_dispatch

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of gPTP receive channels; legal range 1..16.
REQ-002 Parameter TS_W, default 80, timestamp width in bits.
REQ-003 Parameter FRAME_W, default 432, per-port frame bus width; SHALL be at least 2*TS_W+4.
REQ-004 Parameter TYPE_MASK, default 16'h050F, bit n set means messageType n is forwarded.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 gptp_rv_data  input  NUM_PORTS*FRAME_W  per-port frame slice p at [p*FRAME_W +: FRAME_W].
REQ-008 gptp_rv_vaild  input  NUM_PORTS  per-port frame valid.
REQ-009 gptp_rv_ready  output  NUM_PORTS  per-port accept; a frame is consumed when vaild and ready are both high.
REQ-010 rx_rev_wr_ready  input  1  downstream store can take a record.
REQ-011 rx_rev_wr_vaild  output  1  record valid.
REQ-012 rx_rev_wr_addr  output  8  record tag {port[3:0], messageType[3:0]}.
REQ-013 rx_rev_wr_data1  output  TS_W  receive timestamp, frame bits [TS_W-1:0].
REQ-014 rx_rev_wr_data2  output  TS_W  carried timestamp, frame bits [FRAME_W-1 -: TS_W].
REQ-015 drop_cnt  output  NUM_PORTS*16  per-port count of filtered frames, slice p at [p*16 +: 16].

Function
REQ-016 messageType SHALL be taken from frame bits [TS_W+3:TS_W].
REQ-017 Output stage SHALL be one record register; load_en = !rx_rev_wr_vaild || rx_rev_wr_ready.
REQ-018 Round-robin arbiter SHALL grant exactly one valid port per cycle, searching from the port after the last granted port.
REQ-019 gptp_rv_ready SHALL be high only for the granted port, and only when load_en is high; it SHALL be combinational from vaild, the grant pointer and load_en.
REQ-020 The grant pointer SHALL advance to the granted port only on a consumed frame.
REQ-021 Consumed frame with TYPE_MASK[messageType]=1 SHALL appear on the rx_rev_wr_* outputs on the next cycle (latency 1).
REQ-022 Consumed frame with TYPE_MASK[messageType]=0 SHALL be discarded; that port's drop_cnt SHALL increment by 1; the record register SHALL NOT be loaded.
REQ-023 drop_cnt SHALL saturate at 16'hFFFF.
REQ-024 While rx_rev_wr_vaild=1 and rx_rev_wr_ready=0, addr, data1 and data2 SHALL hold stable and all gptp_rv_ready SHALL be 0.
REQ-025 Drain and load in the same cycle SHALL give back-to-back records (throughput 1 record per clk).
REQ-026 Drain with no accepted forwardable frame SHALL clear rx_rev_wr_vaild on the next edge.
REQ-027 Unused upper port bits of rx_rev_wr_addr SHALL be 0 when NUM_PORTS<16.

Reset
REQ-028 On reset: rx_rev_wr_vaild=0, addr/data1/data2=0, all drop_cnt=0, grant pointer selects port 0 as highest priority.
REQ-029 Reset asserted mid-operation SHALL discard any held record without a downstream strobe; gptp_rv_ready SHALL be 0 while reset is high.

Structure
REQ-030 Package gptp_rx_pkg SHALL hold messageType constants (SYNC=0, DELAY_REQ=1, PDELAY_REQ=2, PDELAY_RESP=3, FOLLOW_UP=8, PDELAY_RESP_FU=4'hA, ANNOUNCE=4'hB, SIGNALING=4'hC), the default TYPE_MASK and the field offset functions.
REQ-031 Sub-module gptp_rr_arb SHALL implement the round-robin arbiter (request vector, advance strobe, one-hot grant plus index).

Verification
REQ-032 Port 0, type 3, t1=80'h123456789abc00000001, t2=80'h123456789abc00000002, wr_ready=1 -> one cycle later wr_vaild=1, addr=8'h03, data1=t1, data2=t2.
REQ-033 Same frame on port 2 only -> addr=8'h23.
REQ-034 All 4 ports valid continuously, wr_ready=1 -> grants and addr ports follow 0,1,2,3,0,... with one record per clk.
REQ-035 wr_ready held 0 for 5 cycles with a record pending -> outputs stable, all gptp_rv_ready=0; wr_ready=1 -> next frame loads on the same edge as the drain.
REQ-036 Port 1, type 4'hF -> no wr_vaild, drop_cnt[1] 0->1; 65536 such frames -> drop_cnt[1] stays 16'hFFFF.
REQ-037 Reset pulse while a record is held -> wr_vaild=0 next cycle, counters=0, and the first grant after reset goes to port 0.
